seq_divider: RTL

- Multi-cycle signed integer divider; the inverse of the ALU's Booth multiply path.
- Services the ALU divide opcode (cntrl = 11).
- Produces a quotient and remainder pair in LO/HI style for the datapath.
- Shift-subtract restoring algorithm, one quotient bit per clock, with start/busy/done handshake.

---
 rtl/div_pkg.sv | 18 +
 rtl/seq_divider_if.sv | 28 ++
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 117 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADJ,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 32;

    // Most-negative two's-complement value for a w-bit word (w <= 64), LSB-aligned
    function automatic logic [63:0] most_neg(input int w);
        return 64'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bus of the divider
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/div_step.sv
// div_step: one restoring shift/trial-subtract iteration producing one quotient bit
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem[WIDTH-1:0], i_bit};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    // A bit shifted out of the top means the shifted value certainly exceeds the divisor
    assign o_q     = i_rem[WIDTH] | ~w_diff[WIDTH];
    assign o_rem   = o_q ? w_diff : w_shift;

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider (quotient/remainder) with start/busy/done
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);

    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_ovf_cand;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH:0]   w_prem;
    logic             w_qbit;
    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;

    // Magnitudes as unsigned values; the most-negative input maps to 2^(WIDTH-1)
    assign w_abs_dvd = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_abs_dvs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_prem),
        .i_bit (r_q[WIDTH-1]),
        .i_dvs (r_dvs),
        .o_rem (w_prem),
        .o_q   (w_qbit)
    );

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;

    // Control FSM: accept, iterate one quotient bit per edge, sign-fix, then pulse done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_prem     <= '0;
            r_q        <= '0;
            r_dvs      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_ovf_cand <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dbz <= bus.divisor == '0;
                        r_ovf <= 1'b0;
                        if (bus.divisor == '0) begin
                            r_quo   <= '1;
                            r_rem   <= bus.dividend;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_q        <= w_abs_dvd;
                            r_dvs      <= w_abs_dvs;
                            r_prem     <= '0;
                            r_cnt      <= '0;
                            r_sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_sign_r   <= bus.dividend[WIDTH-1];
                            r_ovf_cand <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                            r_busy     <= 1'b1;
                            r_state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_prem <= w_prem;
                    r_q    <= {r_q[WIDTH-2:0], w_qbit};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ADJ;
                end
                ADJ: begin
                    r_quo   <= r_sign_q ? -r_q : r_q;
                    r_rem   <= r_sign_r ? -r_prem[WIDTH-1:0] : r_prem[WIDTH-1:0];
                    r_ovf   <= r_ovf_cand;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
